// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in serial-out transmitter
//
// Takes a WIDTH-bit word through a valid/ready load handshake and shifts it out
// one bit per clock. The block can take a new word on the cycle that carries
// the final frame bit, so consecutive words stream with no idle gap. This lets
// it feed a SIPO receiver chain directly.
//
// Parameters
//   WIDTH      data bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Optional feature (compile-time macro PISO_PARITY_EN)
//   When defined, one even-parity bit (XOR of the captured word) is appended
//   after the data bits, so a frame is WIDTH+1 bits long. done and the early
//   load_ready move to that parity cycle. When undefined, a frame is WIDTH
//   bits and no parity logic exists.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   parallel_in   word to send; sampled only on an accepted load
//   load_valid    source offers a word
//   load_ready    block accepts a word at the next rising edge
//   serial_out    registered serial data bit
//   serial_valid  high while serial_out carries a frame bit
//   busy          high in the SHIFT state
//   done          high while the final frame bit is on serial_out
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sout_q, sout_d;
    logic [FRAME_LEN-1:0] frame;
    logic                 last_bit;
    logic                 accept;

    // Put the word into transmit order. The result's MSB is the bit that
    // goes out first, so the shifter only ever moves toward the MSB.
    function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST != 0) r[i] = w[i];
            else                r[i] = w[WIDTH-1-i];
        end
        return r;
    endfunction

`ifdef PISO_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    // Counter value 1 marks the final frame bit. A replacement word may be
    // accepted on that cycle, which keeps the stream gapless.
    assign last_bit     = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
    assign load_ready   = (state_q == IDLE) || last_bit;
    assign accept       = load_valid && load_ready;
    assign busy         = (state_q == SHIFT);
    assign serial_valid = (state_q == SHIFT);
    assign done         = last_bit;
    assign serial_out   = sout_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
`ifdef PISO_PARITY_EN
        frame   = {tx_order(parallel_in), even_parity(parallel_in)};
`else
        frame   = tx_order(parallel_in);
`endif
        if (accept) begin
            // The first bit is presented right after the accepting edge.
            // The rest of the frame waits in the shifter.
            sout_d  = frame[FRAME_LEN-1];
            shreg_d = {frame[FRAME_LEN-2:0], 1'b0};
            cnt_d   = CNT_W'(FRAME_LEN);
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                sout_d  = 1'b0;
                shreg_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                sout_d  = shreg_q[FRAME_LEN-1];
                shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : directed self-checking bench for piso_tx
//
// dut  : WIDTH=8, MSB_FIRST=1
// dut2 : WIDTH=8, MSB_FIRST=0
// The bench follows PISO_PARITY_EN, so frames are 9 bits long when the macro
// is defined and 8 bits long otherwise.
// -----------------------------------------------------------------------------
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] parallel_in;
    logic       load_valid;
    logic       load_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       busy;
    logic       done;

    logic [7:0] parallel_in2;
    logic       load_valid2;
    logic       load_ready2;
    logic       serial_out2;
    logic       serial_valid2;
    logic       busy2;
    logic       done2;

    int errors = 0;
    int checks = 0;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in2),
        .load_valid   (load_valid2),
        .load_ready   (load_ready2),
        .serial_out   (serial_out2),
        .serial_valid (serial_valid2),
        .busy         (busy2),
        .done         (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame in send order: the bit at index FL-1-k is frame bit k.
    // The parity bit is computed by hand and passed in by the caller.
    function automatic logic [8:0] fr(input logic [7:0] bits, input logic par);
        if (FL == 9) return {bits, par};
        else         return {1'b0, bits};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check frame bit k of dut, then advance one clock.
    task automatic check_bit(input string tag, input logic [8:0] f, input int k);
        chk({tag, "_bit"},   32'(serial_out),   32'(f[FL-1-k]));
        chk({tag, "_valid"}, 32'(serial_valid), 32'd1);
        chk({tag, "_busy"},  32'(busy),         32'd1);
        chk({tag, "_done"},  32'(done),         32'(k == FL-1));
        chk({tag, "_ready"}, 32'(load_ready),   32'(k == FL-1));
        step();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(serial_valid), 32'd0);
        chk({tag, "_sout"},  32'(serial_out),   32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_done"},  32'(done),         32'd0);
        chk({tag, "_ready"}, 32'(load_ready),   32'd1);
    endtask

    initial begin
        logic [8:0] f;
        reset        = 1'b1;
        parallel_in  = 8'h00;
        load_valid   = 1'b0;
        parallel_in2 = 8'h00;
        load_valid2  = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_idle("rst");
        step();
        reset = 1'b1;

        // Single word 0xA5, MSB first: 1,0,1,0,0,1,0,1 (parity 0).
        parallel_in = 8'hA5;
        load_valid  = 1'b1;
        step();
        load_valid  = 1'b0;
        parallel_in = 8'h00;
        f = fr(8'b1010_0101, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("a5", f, k);
        check_idle("a5_end");
        step();
        check_idle("a5_end2");

        // Back-to-back 0xFF then 0x00 with load_valid held high. parallel_in
        // changes right after the first accept and must not disturb 0xFF.
        parallel_in = 8'hFF;
        load_valid  = 1'b1;
        step();
        parallel_in = 8'h00;
        f = fr(8'hFF, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("ff", f, k);
        load_valid = 1'b0;
        f = fr(8'h00, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("b2b00", f, k);
        check_idle("b2b_end");

        // Load offered in the third bit cycle of 0x96 is held off until the
        // final bit, then 0x3C follows without a gap.
        parallel_in = 8'h96;
        load_valid  = 1'b1;
        step();
        load_valid = 1'b0;
        f = fr(8'b1001_0110, 1'b0);
        for (int k = 0; k < 2; k++) check_bit("96", f, k);
        parallel_in = 8'h3C;
        load_valid  = 1'b1;
        for (int k = 2; k < FL; k++) check_bit("96", f, k);
        load_valid = 1'b0;
        f = fr(8'b0011_1100, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("3c", f, k);
        check_idle("3c_end");

        // Reset mid-frame after four bits of 0x81. Outputs must clear
        // without waiting for a clock edge.
        parallel_in = 8'h81;
        load_valid  = 1'b1;
        step();
        load_valid = 1'b0;
        f = fr(8'b1000_0001, 1'b0);
        for (int k = 0; k < 4; k++) check_bit("81", f, k);
        reset = 1'b0;
        #1;
        check_idle("midrst");
        #1;
        reset       = 1'b1;
        parallel_in = 8'h42;
        load_valid  = 1'b1;
        step();
        load_valid = 1'b0;
        f = fr(8'b0100_0010, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("42", f, k);
        check_idle("42_end");

        // Words 0x07 and 0x03 back to back. Their parity bits are 1 and 0.
        parallel_in = 8'h07;
        load_valid  = 1'b1;
        step();
        parallel_in = 8'h03;
        f = fr(8'b0000_0111, 1'b1);
        for (int k = 0; k < FL; k++) check_bit("07", f, k);
        load_valid = 1'b0;
        f = fr(8'b0000_0011, 1'b0);
        for (int k = 0; k < FL; k++) check_bit("03", f, k);
        check_idle("03_end");

        // LSB-first unit sending 0x01: 1 then seven 0s, with parity 1.
        parallel_in2 = 8'h01;
        load_valid2  = 1'b1;
        step();
        load_valid2 = 1'b0;
        f = fr(8'b1000_0000, 1'b1);
        for (int k = 0; k < FL; k++) begin
            chk("lsb_bit",   32'(serial_out2),   32'(f[FL-1-k]));
            chk("lsb_valid", 32'(serial_valid2), 32'd1);
            chk("lsb_done",  32'(done2),         32'(k == FL-1));
            step();
        end
        chk("lsb_end_valid", 32'(serial_valid2), 32'd0);
        chk("lsb_end_sout",  32'(serial_out2),   32'd0);
        chk("lsb_end_ready", 32'(load_ready2),   32'd1);
        chk("lsb_end_busy",  32'(busy2),         32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It is the sending end that feeds the team's SIPO shift-register receiver.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per clock, MSB first. This order means the first bit sent lands in the receiver's top bit after WIDTH shifts.
- Supports gapless back-to-back words for streaming into the SIPO chain.

Parameters:
WIDTH, 8, number of data bits per word (minimum 2).
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
parallel_in  input  WIDTH  word to transmit; sampled only on an accepted load.
load_valid  input  1  source has a word on parallel_in.
load_ready  output  1  block can accept a word at the next rising edge.
serial_out  output  1  serial data bit, registered.
serial_valid  output  1  high while serial_out carries a frame bit.
busy  output  1  high in SHIFT state.
done  output  1  one-cycle pulse, high while the final frame bit is on serial_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register and bit counter cleared.
  - serial_out=0, serial_valid=0, busy=0, done=0, load_ready=1 while IDLE.
  - Reset mid-frame discards the word; no done pulse. After release, the first edge can accept a new word.
- States: IDLE, SHIFT.
- Accept: load_valid=1 and load_ready=1 at a rising edge. On accept:
  - parallel_in is captured.
  - Bit counter loads with FRAME_LEN. FRAME_LEN = WIDTH, or WIDTH+1 with parity.
  - State goes to SHIFT.
- Latency: the word is accepted at edge N. After edge N, serial_out holds the first bit (parallel_in[WIDTH-1] when MSB_FIRST=1) and serial_valid=1.
  - Each later edge presents the next bit.
  - Frame bit k is valid after edge N+k, for k = 0..FRAME_LEN-1.
- load_ready rules:
  - High in IDLE.
  - High in SHIFT only while the final frame bit is presented (counter==1).
  - Low otherwise.
- End of frame:
  - done=1 and busy=1 in the cycle the final bit is presented.
  - At the next edge, with no accept: state=IDLE, serial_valid=0, serial_out=0, busy=0.
  - At the next edge, with an accept: the first bit of the new word appears immediately. serial_valid stays high, busy stays high, there is no idle gap, and done falls.
- load_valid while load_ready=0 is ignored. parallel_in changes mid-frame do not affect the frame in progress.
- The source must hold parallel_in stable only at the accepting edge.
- The counter never wraps. Going from 1 to 0 without an accept returns the block to IDLE.
- Receiver pairing: the SIPO samples serial_out on the same clk when serial_valid=1. After WIDTH valid cycles with MSB_FIRST=1, the receiver holds the original word.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of the captured word) is appended after the data bits. FRAME_LEN=WIDTH+1.
  - done and early load_ready move to the parity-bit cycle.
  - Parity is computed from the captured word, not the live parallel_in.
- Undefined:
  - FRAME_LEN=WIDTH, no parity logic, behaviour exactly as above.

Test Plan:
- Reset, then a single word 0xA5 (WIDTH=8, MSB_FIRST=1) -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_valid high exactly 8 cycles; done high on the 8th only; then IDLE with serial_out=0.
- Back-to-back 0xFF then 0x00, load_valid held high -> 16 contiguous serial_valid cycles: eight 1s then eight 0s. load_ready high only on the last-bit cycle of the first word. Two done pulses, 8 cycles apart.
- Drive load_valid=1 with 0x3C in the third bit cycle of a frame -> ignored. The current frame is unchanged, and 0x3C is accepted at the last-bit edge (or later if load_valid is held).
- Assert reset low mid-frame after 4 bits of 0x81 -> outputs clear asynchronously, no done. After release, 0x42 transmits correctly starting on the first accept.
- MSB_FIRST=0 with 0x01 -> serial_out 1 then seven 0s.
- PISO_PARITY_EN defined, words 0x07 and 0x03 -> parity bits 1 and 0 respectively. serial_valid 9 cycles per frame; done on the parity cycle.
